arm_ldm_stm_seq: RTL

Multi-cycle sequencer for ARM block data transfer instructions (LDM/STM). It sits beside the single-cycle decoder and datapath. When the decoder flags a condition-passed LDM/STM, the sequencer freezes the PC, walks the 16-bit register list in ascending order and issues one word transfer per listed register over a ready-handshake memory port. It then optionally writes back the base register.

---
 rtl/arm_ldm_stm_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/arm_ldm_stm_seq.sv
// LDM/STM block-transfer sequencer. It freezes the PC, walks the register list
// in ascending order, and issues one word transfer per listed register over a
// ready-handshake port. It can then write the updated base back to Rn.
module arm_ldm_stm_seq #(
  parameter int ADDR_W   = 32,
  parameter int MAX_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       inst,
  input  logic [ADDR_W-1:0] rn_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic              stall_pc,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        reg_idx,
  output logic              rf_we,
  output logic              pc_we,
  output logic [3:0]        rn_idx,
  output logic              rn_we,
  output logic [ADDR_W-1:0] rn_wb_data,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  state_t              state, state_nxt;
  logic [MAX_REGS-1:0] list_q, list_nxt;
  logic                l_q, w_q, rn_in_list_q;
  logic [3:0]          rn_q;
  logic [ADDR_W-1:0]   addr_q, wb_q;

  // Instruction fields; cond/opcode/S bits are the decoder's business
  logic                unused_inst;
  assign unused_inst = ^{inst[31:25], inst[22]};

  logic              p_bit, u_bit;
  logic [4:0]        n_regs;
  logic [ADDR_W-1:0] four_n, start_addr, wb_val;
  logic [3:0]        cur_idx;
  logic              last_xfer;

  assign p_bit = inst[24];
  assign u_bit = inst[23];

  // Decode the incoming instruction: register count, start address and writeback value
  always_comb begin
    n_regs = '0;
    for (int i = 0; i < MAX_REGS; i++) n_regs = n_regs + 5'(inst[i]);
    four_n = ADDR_W'({n_regs, 2'b00});
    unique case ({p_bit, u_bit})
      2'b01:   start_addr = rn_data;                                // IA
      2'b11:   start_addr = rn_data + ADDR_W'(4);                   // IB
      2'b00:   start_addr = rn_data - four_n + ADDR_W'(4);          // DA
      default: start_addr = rn_data - four_n;                       // DB
    endcase
    wb_val = u_bit ? rn_data + four_n : rn_data - four_n;
  end

  // Find the lowest remaining register and the list left after it is retired
  always_comb begin
    cur_idx = '0;
    for (int i = MAX_REGS - 1; i >= 0; i--) if (list_q[i]) cur_idx = 4'(i);
    list_nxt  = list_q & (list_q - 1'b1);
    last_xfer = (list_nxt == '0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (n_regs == '0) ? DONE : XFER;
      XFER: if (mem_ready && last_xfer) state_nxt = w_q ? WB : DONE;
      WB:   state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the instruction at start, then retire one register per accepted transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      list_q       <= '0;
      l_q          <= 1'b0;
      w_q          <= 1'b0;
      rn_q         <= '0;
      rn_in_list_q <= 1'b0;
      addr_q       <= '0;
      wb_q         <= '0;
    end else if (state == IDLE && start) begin
      list_q       <= inst[MAX_REGS-1:0];
      l_q          <= inst[20];
      w_q          <= inst[21];
      rn_q         <= inst[19:16];
      rn_in_list_q <= inst[inst[19:16]];
      addr_q       <= start_addr;
      wb_q         <= wb_val;
    end else if (state == XFER && mem_ready) begin
      list_q <= list_nxt;
      addr_q <= addr_q + ADDR_W'(4);
    end
  end

  // Outputs decoded from state; loads retire into the RF or the PC on mem_ready
  always_comb begin
    busy       = (state != IDLE);
    stall_pc   = (start & ~rst) | busy;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    reg_idx    = '0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    rn_idx     = rn_q;
    rn_we      = 1'b0;
    rn_wb_data = wb_q;
    done       = 1'b0;
    unique case (state)
      XFER: begin
        mem_en   = 1'b1;
        mem_we   = ~l_q;
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        reg_idx  = cur_idx;
        rf_we    = l_q & mem_ready & (cur_idx != 4'(MAX_REGS - 1));
        pc_we    = l_q & mem_ready & (cur_idx == 4'(MAX_REGS - 1));
      end
      // A load that includes Rn keeps the loaded value instead of the writeback
      WB:      rn_we = ~(l_q & rn_in_list_q);
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

endmodule
